free_list: RTL and testbench
============================

Name: free_list

Overview:
- Circular FIFO of free physical register tags. Sits directly upstream of the rename map table and supplies its per-lane new-destination tags (pr_freelist).
- Tags are popped at dispatch and pushed back at retirement, using the T_old each retiring ROB entry carries.
- Keeps a speculative head and an architectural head, so that a branch hazard restores the list in one cycle.

Parameters:
- N_WAY, 2, dispatch/retire superscalar width.
- CDB_BITS, 6, physical tag width. Tag 0 means "no tag".
- ARCH_REGS, 32, architectural register count. Tags 1..ARCH_REGS are mapped at reset.
- PR_NUM, 64, total physical registers. Must equal 2**CDB_BITS.
- FL_DEPTH, 32, FIFO slots. Power of two, and at least PR_NUM-ARCH_REGS-1.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low reset: state clears on the rising edge of clock while reset==0.
- dis_req  in  N_WAY  lane wants a new destination tag. Dispatch never raises it for dest x0.
- branch_haz  in  1  mispredict recovery.
- retire_valid  in  N_WAY  lane retires this cycle.
- retire_told  in  N_WAY*CDB_BITS  T_old of the retiring lane. A value of 0 means the lane has no destination.
- pr_freelist  out  N_WAY*CDB_BITS  tag granted per lane, combinational from the current state. 0 means not granted.
- free_count  out  log2(FL_DEPTH)+1  number of entries currently free in the speculative view.
- fl_empty  out  1  high when free_count==0.

Behaviour:
- State:
  - mem[FL_DEPTH] of CDB_BITS.
  - Pointers spec_head, arch_head and tail, each log2(FL_DEPTH)+1 bits (the extra MSB is the wrap bit). Indexing uses the low bits.
  - free_count = tail - spec_head, modulo pointer width.
- Reset (reset==0 at a clock edge):
  - mem[k] = ARCH_REGS+1+k for k < PR_NUM-ARCH_REGS-1, otherwise 0.
  - spec_head = arch_head = 0; tail = PR_NUM-ARCH_REGS-1 (31).
  - Outputs after reset: pr_freelist = 0 whenever dis_req == 0; free_count = 31; fl_empty = 0.
- Reset mid-operation discards all allocations and pending retirements. It has priority over every other input.
- Allocation:
  - Lanes are scanned from 0 to N_WAY-1. The r-th requesting lane (r counted from 0) gets mem[spec_head+r], but only if r < free_count; otherwise it gets 0.
  - Non-requesting lanes always get 0.
  - At the clock edge, spec_head advances by the number of granted lanes.
  - Grants are partial: when free_count=1 and both lanes request, lane 0 gets the tag and lane 1 gets 0. Dispatch stalls lane 1.
- Retirement:
  - Each lane with retire_valid=1 and retire_told != 0 pushes retire_told at tail, packed in lane order.
  - tail advances by the push count. arch_head advances by the same count (one allocation committed per freed T_old).
  - A pushed tag is not visible to pr_freelist until the next cycle. There is no same-cycle bypass.
- Branch hazard (branch_haz=1):
  - spec_head <= arch_head + (retire pushes in the same cycle).
  - dis_req is ignored that cycle: pr_freelist = 0 and nothing is allocated.
  - Same-cycle retirement is still applied to both tail and arch_head.
- Overflow is impossible by construction, because the physical tag count bounds occupancy. Debug builds assert free_count <= FL_DEPTH.
- Wrap-around is handled purely by pointer modulo arithmetic. Full and empty are distinguished by the wrap bit.
- Latency: grant is combinational in the same cycle. State updates one cycle later.

Test Plan:
1. Reset held low 2 cycles, then released; dis_req=2'b11 -> pr_freelist={34,33} (lane1 = 34, lane0 = 33); free_count=31; next cycle free_count=29.
2. dis_req=2'b11 for 15 cycles from reset (tags 33..62 granted), then dis_req=2'b11 again -> lane0=63, lane1=0, free_count=1. Following cycle: fl_empty=1 and both lanes get 0.
3. From the empty state: retire_valid=2'b11, retire_told={7,5} -> same cycle pr_freelist stays 0. Next cycle free_count=2, dis_req=2'b11 -> lane0=5, lane1=7. Check that the tail and head wrap past slot 31.
4. After reset: dis_req=2'b11 for 2 cycles (33..36 granted), then retire lane0 told=1 together with branch_haz=1 -> next cycle free_count=31 and dis_req=2'b01 gives lane0=34.
5. After reset, dis_req=2'b10 -> lane1=33, lane0=0; next cycle dis_req=2'b01 -> lane0=34.
6. Mid-stream (free_count=10, retire pending), reset=0 for 1 cycle -> free_count=31, dis_req=2'b01 gives 33, and the pending retire is discarded.

Source files
------------

// File: rtl/free_list_if.sv
// rtl/free_list_if.sv - dispatch/retire/grant bundle between rename logic and the free list
interface free_list_if #(
    parameter int N_WAY    = 2,
    parameter int CDB_BITS = 6,
    parameter int FL_DEPTH = 32
);
    localparam int CW = $clog2(FL_DEPTH) + 1;

    logic [N_WAY-1:0]          dis_req;
    logic                      branch_haz;
    logic [N_WAY-1:0]          retire_valid;
    logic [N_WAY*CDB_BITS-1:0] retire_told;
    logic [N_WAY*CDB_BITS-1:0] pr_freelist;
    logic [CW-1:0]             free_count;
    logic                      fl_empty;

    modport master (
        output dis_req, branch_haz, retire_valid, retire_told,
        input  pr_freelist, free_count, fl_empty
    );

    modport slave (
        input  dis_req, branch_haz, retire_valid, retire_told,
        output pr_freelist, free_count, fl_empty
    );
endinterface

// File: rtl/free_list.sv
// rtl/free_list.sv - circular FIFO of free physical tags with speculative and architectural heads
module free_list #(
    parameter int N_WAY     = 2,
    parameter int CDB_BITS  = 6,
    parameter int ARCH_REGS = 32,
    parameter int PR_NUM    = 64,
    parameter int FL_DEPTH  = 32
) (
    input  logic          clock,
    input  logic          reset,
    free_list_if.slave    fl
);
    localparam int IW = $clog2(FL_DEPTH);
    localparam int PW = IW + 1;
    localparam int INIT_FREE = PR_NUM - ARCH_REGS - 1;
    localparam logic [PW-1:0] ONE = PW'(1);

    logic [CDB_BITS-1:0] mem_q [FL_DEPTH];
    logic [PW-1:0] spec_head_q, spec_head_d;
    logic [PW-1:0] arch_head_q, arch_head_d;
    logic [PW-1:0] tail_q, tail_d;

    logic [PW-1:0] free_cnt, grant_cnt, push_cnt, rd_ptr, wr_ptr;
    logic [N_WAY-1:0]          wr_en;
    logic [IW-1:0]             wr_idx [N_WAY];
    logic [N_WAY*CDB_BITS-1:0] grant;

    // Grants read the state as of this cycle only; pushes land for the next cycle.
    always_comb begin
        free_cnt  = tail_q - spec_head_q;
        grant     = '0;
        grant_cnt = '0;
        push_cnt  = '0;
        rd_ptr    = '0;
        wr_ptr    = '0;
        wr_en     = '0;
        for (int i = 0; i < N_WAY; i++) begin
            wr_idx[i] = '0;
        end
        for (int i = 0; i < N_WAY; i++) begin
            if (fl.dis_req[i] && !fl.branch_haz && (grant_cnt < free_cnt)) begin
                rd_ptr = spec_head_q + grant_cnt;
                grant[i*CDB_BITS +: CDB_BITS] = mem_q[rd_ptr[IW-1:0]];
                grant_cnt = grant_cnt + ONE;
            end
            if (fl.retire_valid[i] && (fl.retire_told[i*CDB_BITS +: CDB_BITS] != '0)) begin
                wr_ptr    = tail_q + push_cnt;
                wr_en[i]  = 1'b1;
                wr_idx[i] = wr_ptr[IW-1:0];
                push_cnt  = push_cnt + ONE;
            end
        end
        tail_d      = tail_q + push_cnt;
        arch_head_d = arch_head_q + push_cnt;
        spec_head_d = fl.branch_haz ? (arch_head_q + push_cnt) : (spec_head_q + grant_cnt);
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int k = 0; k < FL_DEPTH; k++) begin
                mem_q[k] <= (k < INIT_FREE) ? CDB_BITS'(ARCH_REGS + 1 + k) : '0;
            end
            spec_head_q <= '0;
            arch_head_q <= '0;
            tail_q      <= PW'(INIT_FREE);
        end else begin
            for (int i = 0; i < N_WAY; i++) begin
                if (wr_en[i]) begin
                    mem_q[wr_idx[i]] <= fl.retire_told[i*CDB_BITS +: CDB_BITS];
                end
            end
            spec_head_q <= spec_head_d;
            arch_head_q <= arch_head_d;
            tail_q      <= tail_d;
        end
    end

    assign fl.pr_freelist = grant;
    assign fl.free_count  = free_cnt;
    assign fl.fl_empty    = (free_cnt == '0);

    // Occupancy is bounded by the tag count, so this can only fire on a protocol error upstream.
    assert property (@(posedge clock) disable iff (!reset) free_cnt <= PW'(FL_DEPTH));
endmodule

// File: tb/tb_free_list.sv
// tb/tb_free_list.sv - scoreboard bench for free_list with directed vectors
module tb_free_list;
    logic clock;
    logic reset;

    free_list_if #(.N_WAY(2), .CDB_BITS(6), .FL_DEPTH(32)) fif ();

    free_list #(
        .N_WAY(2), .CDB_BITS(6), .ARCH_REGS(32), .PR_NUM(64), .FL_DEPTH(32)
    ) dut (
        .clock (clock),
        .reset (reset),
        .fl    (fif.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        string      name;
        logic [2:0] mask;
        logic [11:0] pf;
        logic [5:0] fc;
        logic       emp;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur;
    int   errors = 0;
    int   checks = 0;

    // Monitor: outputs are combinational, so compare mid-cycle once the vector is applied.
    always @(negedge clock) begin
        if (exp_q.size() > 0) begin
            cur = exp_q.pop_front();
            if (cur.mask[0]) begin
                checks++;
                if (fif.pr_freelist !== cur.pf) begin
                    errors++;
                    $display("FAIL %s pr_freelist got={%0d,%0d} exp={%0d,%0d}", cur.name,
                             fif.pr_freelist[11:6], fif.pr_freelist[5:0], cur.pf[11:6], cur.pf[5:0]);
                end
            end
            if (cur.mask[1]) begin
                checks++;
                if (fif.free_count !== cur.fc) begin
                    errors++;
                    $display("FAIL %s free_count got=%0d exp=%0d", cur.name, fif.free_count, cur.fc);
                end
            end
            if (cur.mask[2]) begin
                checks++;
                if (fif.fl_empty !== cur.emp) begin
                    errors++;
                    $display("FAIL %s fl_empty got=%0d exp=%0d", cur.name, fif.fl_empty, cur.emp);
                end
            end
        end
    end

    task automatic step(input logic rst, input logic [1:0] dis, input logic bh,
                        input logic [1:0] rv, input int t1, input int t0,
                        input logic [2:0] m, input int p1, input int p0,
                        input int fc, input logic emp, input string nm);
        exp_t e;
        reset            = rst;
        fif.dis_req      = dis;
        fif.branch_haz   = bh;
        fif.retire_valid = rv;
        fif.retire_told  = {6'(t1), 6'(t0)};
        e.name = nm;
        e.mask = m;
        e.pf   = {6'(p1), 6'(p0)};
        e.fc   = 6'(fc);
        e.emp  = emp;
        exp_q.push_back(e);
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        step(1'b0, 2'b00, 1'b0, 2'b00, 0, 0, 3'b000, 0, 0, 0, 1'b0, "rst");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b0;
        fif.dis_req = '0;
        fif.branch_haz = 1'b0;
        fif.retire_valid = '0;
        fif.retire_told = '0;
        repeat (2) @(posedge clock);
        #1;

        // 1: first dual grant after reset
        step(1, 2'b11, 0, 2'b00, 0, 0, 3'b111, 34, 33, 31, 0, "t1_grant");
        step(1, 2'b00, 0, 2'b00, 0, 0, 3'b111, 0, 0, 29, 0, "t1_count");

        // 2: drain to empty, partial grant at free_count=1
        do_reset();
        for (int k = 0; k < 15; k++)
            step(1, 2'b11, 0, 2'b00, 0, 0, 3'b111, 34 + 2*k, 33 + 2*k, 31 - 2*k, 0, "t2_drain");
        step(1, 2'b11, 0, 2'b00, 0, 0, 3'b111, 0, 63, 1, 0, "t2_partial");
        step(1, 2'b11, 0, 2'b00, 0, 0, 3'b111, 0, 0, 0, 1, "t2_empty");

        // 3: retire into empty list across the slot-31 wrap, no same-cycle bypass
        step(1, 2'b11, 0, 2'b11, 7, 5, 3'b111, 0, 0, 0, 1, "t3_nobypass");
        step(1, 2'b11, 0, 2'b00, 0, 0, 3'b111, 7, 5, 2, 0, "t3_wrapgrant");
        step(1, 2'b00, 0, 2'b01, 0, 9, 3'b111, 0, 0, 0, 1, "t3_empty2");
        step(1, 2'b01, 0, 2'b00, 0, 0, 3'b111, 0, 9, 1, 0, "t3_wrap2");

        // 4: branch hazard restores to arch_head plus same-cycle retire
        do_reset();
        step(1, 2'b11, 0, 2'b00, 0, 0, 3'b111, 34, 33, 31, 0, "t4_a");
        step(1, 2'b11, 0, 2'b00, 0, 0, 3'b111, 36, 35, 29, 0, "t4_b");
        step(1, 2'b11, 1, 2'b01, 0, 1, 3'b111, 0, 0, 27, 0, "t4_haz");
        step(1, 2'b01, 0, 2'b00, 0, 0, 3'b111, 0, 34, 31, 0, "t4_restored");

        // 5: lone lane-1 request takes the head tag
        do_reset();
        step(1, 2'b10, 0, 2'b00, 0, 0, 3'b111, 33, 0, 31, 0, "t5_lane1");
        step(1, 2'b01, 0, 2'b00, 0, 0, 3'b111, 0, 34, 30, 0, "t5_lane0");

        // 6: reset mid-stream drops allocations and the pending retire
        do_reset();
        for (int k = 0; k < 10; k++)
            step(1, 2'b11, 0, 2'b00, 0, 0, 3'b010, 0, 0, 31 - 2*k, 0, "t6_fill");
        step(1, 2'b01, 0, 2'b00, 0, 0, 3'b111, 0, 53, 11, 0, "t6_one");
        step(0, 2'b11, 0, 2'b01, 0, 40, 3'b111, 55, 54, 10, 0, "t6_prereset");
        step(1, 2'b01, 0, 2'b00, 0, 0, 3'b111, 0, 33, 31, 0, "t6_after");
        step(1, 2'b00, 0, 2'b00, 0, 0, 3'b111, 0, 0, 30, 0, "t6_discard");

        @(negedge clock);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain queue_left got=%0d exp=0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
